// File: rtl/compressor_block_dispatch.sv
// Block-streaming compressor front end. Pixel blocks arrive one per valid/ready
// handshake and are dealt round-robin to NUM_LANES compress_block cores. Results
// are parked in per-lane result registers and released strictly in arrival order,
// tagged with their block row/col within the image.

// Stand-in transform core. It models the core timing contract: block_done
// pulses LATENCY cycles after start_block. coeffs is the sign-extended pixel
// block, so the dispatcher can be exercised end to end. LATENCY must be >= 1.
module compress_block #(
  parameter int BLOCK_SIZE    = 8,
  parameter int PIX_WIDTH     = 9,
  parameter int DCT_OUT_WIDTH = 54,
  parameter int LATENCY       = 5
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            start_block,
  input  logic [BLOCK_SIZE*BLOCK_SIZE*PIX_WIDTH-1:0]      block,
  output logic                                            block_done,
  output logic [BLOCK_SIZE*BLOCK_SIZE*DCT_OUT_WIDTH-1:0]  coeffs
);
  localparam int NPIX = BLOCK_SIZE * BLOCK_SIZE;

  logic [7:0] cnt;

  function automatic logic signed [DCT_OUT_WIDTH-1:0] sext_pix(
    input logic signed [PIX_WIDTH-1:0] p
  );
    return DCT_OUT_WIDTH'(p);
  endfunction

  // Countdown of the in-flight block; done fires when the count reaches one.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (start_block) begin
      cnt <= 8'(LATENCY);
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign block_done = (cnt == 8'd1);

  // Per-pixel transform: widen each signed pixel into the coefficient format.
  always_comb begin
    coeffs = '0;
    for (int k = 0; k < NPIX; k++) begin
      coeffs[k*DCT_OUT_WIDTH +: DCT_OUT_WIDTH] = sext_pix(block[k*PIX_WIDTH +: PIX_WIDTH]);
    end
  end
endmodule

module compressor_block_dispatch #(
  parameter int BLOCK_SIZE     = 8,
  parameter int PIX_WIDTH      = 9,
  parameter int DCT_OUT_WIDTH  = 54,
  parameter int NUM_LANES      = 4,
  parameter int LANE_IDX_WIDTH = 2,
  parameter int BLK_CTR_WIDTH  = 7,
  parameter int MAX_BLK_ROWS   = 60,
  parameter int MAX_BLK_COLS   = 80,
  // Per-lane core latency, 8 bits per lane, lane 0 in the low byte.
  parameter logic [NUM_LANES*8-1:0] LANE_LATENCY = {NUM_LANES{8'd5}}
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            start_img,
  input  logic                                            abort,
  input  logic [BLK_CTR_WIDTH-1:0]                        cfg_blk_rows,
  input  logic [BLK_CTR_WIDTH-1:0]                        cfg_blk_cols,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic [BLOCK_SIZE*BLOCK_SIZE*PIX_WIDTH-1:0]      in_block,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [BLOCK_SIZE*BLOCK_SIZE*DCT_OUT_WIDTH-1:0]  out_coeffs,
  output logic [BLK_CTR_WIDTH-1:0]                        out_blk_row,
  output logic [BLK_CTR_WIDTH-1:0]                        out_blk_col,
  output logic                                            out_last,
  output logic                                            busy,
  output logic                                            img_done,
  output logic                                            cfg_err
);
  localparam int NPIX  = BLOCK_SIZE * BLOCK_SIZE;
  localparam int IN_W  = NPIX * PIX_WIDTH;
  localparam int OUT_W = NPIX * DCT_OUT_WIDTH;
  localparam int ACC_W = 2 * BLK_CTR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  // FLUSH marks a lane whose block was abandoned by abort; its next done is dropped.
  typedef enum logic [1:0] {L_FREE, L_BUSY, L_FULL, L_FLUSH} lane_t;

  state_t                     state, state_nxt;
  lane_t                      lane_st [NUM_LANES];
  logic [LANE_IDX_WIDTH-1:0]  wr_ptr, rd_ptr;
  logic [BLK_CTR_WIDTH-1:0]   cfg_rows, cfg_cols, out_row, out_col;
  logic [ACC_W-1:0]           acc_cnt, total_blks;
  logic [NUM_LANES-1:0]       start_p, done_v, flush_v;
  logic [IN_W-1:0]            lane_in  [NUM_LANES];
  logic [OUT_W-1:0]           lane_res [NUM_LANES];
  logic [OUT_W-1:0]           core_coeffs [NUM_LANES];
  logic                       cfg_legal, start_ok, start_bad, in_fire, out_fire;
  logic                       any_flush, cfg_err_r, tag_last;

  assign cfg_legal = (cfg_blk_rows != '0) && (cfg_blk_rows <= BLK_CTR_WIDTH'(MAX_BLK_ROWS)) &&
                     (cfg_blk_cols != '0) && (cfg_blk_cols <= BLK_CTR_WIDTH'(MAX_BLK_COLS));

  // Lanes still waiting on an abandoned block hold off the next image.
  always_comb begin
    flush_v = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      flush_v[i] = (lane_st[i] == L_FLUSH);
    end
  end

  assign any_flush  = |flush_v;
  assign start_ok   = (state == S_IDLE) && start_img && !abort && cfg_legal && !any_flush;
  assign start_bad  = (state == S_IDLE) && start_img && !abort && !cfg_legal;
  assign total_blks = ACC_W'(cfg_rows) * ACC_W'(cfg_cols);

  assign in_ready = (state == S_RUN) && (lane_st[wr_ptr] == L_FREE) && (acc_cnt < total_blks);
  assign in_fire  = in_valid && in_ready && !abort;

  assign tag_last  = (out_row == cfg_rows - 1'b1) && (out_col == cfg_cols - 1'b1);
  assign out_valid = (state == S_RUN) && (lane_st[rd_ptr] == L_FULL);
  assign out_fire  = out_valid && out_ready && !abort;

  // Output fields read zero whenever nothing is being offered.
  assign out_coeffs  = out_valid ? lane_res[rd_ptr] : '0;
  assign out_blk_row = out_valid ? out_row : '0;
  assign out_blk_col = out_valid ? out_col : '0;
  assign out_last    = out_valid && tag_last;
  assign busy        = (state != S_IDLE);
  assign img_done    = (state == S_DONE);
  assign cfg_err     = cfg_err_r;

  // Image-level next state; abort overrides everything.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_RUN;
      S_RUN:   if (out_fire && tag_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  // Image state, config capture, pointers, block counters and start pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cfg_rows  <= '0;
      cfg_cols  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      acc_cnt   <= '0;
      out_row   <= '0;
      out_col   <= '0;
      start_p   <= '0;
      cfg_err_r <= 1'b0;
    end else begin
      state     <= state_nxt;
      cfg_err_r <= start_bad;
      start_p   <= '0;
      if (abort) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        acc_cnt <= '0;
        out_row <= '0;
        out_col <= '0;
      end else begin
        if (start_ok) begin
          cfg_rows <= cfg_blk_rows;
          cfg_cols <= cfg_blk_cols;
          wr_ptr   <= '0;
          rd_ptr   <= '0;
          acc_cnt  <= '0;
          out_row  <= '0;
          out_col  <= '0;
        end
        if (in_fire) begin
          start_p[wr_ptr] <= 1'b1;
          wr_ptr          <= wr_ptr + 1'b1;
          acc_cnt         <= acc_cnt + 1'b1;
        end
        if (out_fire) begin
          rd_ptr <= rd_ptr + 1'b1;
          if (out_col == cfg_cols - 1'b1) begin
            out_col <= '0;
            out_row <= out_row + 1'b1;
          end else begin
            out_col <= out_col + 1'b1;
          end
        end
      end
    end
  end

  // Per-lane occupancy: FREE -> BUSY -> FULL -> FREE, with FLUSH after abort.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (rst) begin
        lane_st[i] <= L_FREE;
      end else begin
        case (lane_st[i])
          L_FREE:  if (in_fire && wr_ptr == LANE_IDX_WIDTH'(i)) lane_st[i] <= L_BUSY;
          L_BUSY: begin
            // A done arriving together with abort already retires the block.
            if (abort)          lane_st[i] <= done_v[i] ? L_FREE : L_FLUSH;
            else if (done_v[i]) lane_st[i] <= L_FULL;
          end
          L_FULL:  if (abort || (out_fire && rd_ptr == LANE_IDX_WIDTH'(i))) lane_st[i] <= L_FREE;
          L_FLUSH: if (done_v[i]) lane_st[i] <= L_FREE;
          default: lane_st[i] <= L_FREE;
        endcase
      end
    end
  end

  // Lane data registers: input block held for the core, result captured on done.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (in_fire && wr_ptr == LANE_IDX_WIDTH'(i)) lane_in[i] <= in_block;
      if (done_v[i] && lane_st[i] == L_BUSY)       lane_res[i] <= core_coeffs[i];
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    compress_block #(
      .BLOCK_SIZE    (BLOCK_SIZE),
      .PIX_WIDTH     (PIX_WIDTH),
      .DCT_OUT_WIDTH (DCT_OUT_WIDTH),
      .LATENCY       (int'(LANE_LATENCY[g*8 +: 8]))
    ) u_core (
      .clk         (clk),
      .rst         (rst),
      .start_block (start_p[g]),
      .block       (lane_in[g]),
      .block_done  (done_v[g]),
      .coeffs      (core_coeffs[g])
    );
  end
endmodule
